// File: rtl/instr_loader_pkg.sv
`default_nettype none
// instr_loader_pkg: state encodings, image header size and default memory size
// shared by the boot loader and the instruction memory.
package instr_loader_pkg;

    localparam int HDR_BYTES         = 4;
    localparam int DEFAULT_MEM_BYTES = 1024;
    localparam int STATE_W           = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEN  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA = 3'd2;
    localparam logic [STATE_W-1:0] ST_CSUM = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd5;

    function automatic logic accepts_bytes(input logic [STATE_W-1:0] st);
        return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

    function automatic logic can_restart(input logic [STATE_W-1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// instr_loader: receives a length-prefixed, checksummed byte image and writes it
// into instruction memory, holding the core in reset until the image is good.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // One extra count so the counter can reach MEM_BYTES after the last byte.
    localparam int          CNT_W     = $clog2(MEM_BYTES + 1);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        len;
    logic [7:0]         sum;

    logic               accept;
    logic [31:0]        cnt_ext;
    logic [31:0]        len_next;

    assign in_ready = accepts_bytes(state);
    assign accept   = in_valid && in_ready;
    assign cnt_ext  = 32'(cnt);
    assign len_next = {len[23:0], in_data};

    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERR);
    assign cpu_hold = (state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            len     <= '0;
            sum     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_LEN: begin
                    if (accept) begin
                        len <= len_next;
                        if (cnt == HDR_LAST) begin
                            cnt <= '0;
                            if (len_next > MEM_LIMIT)
                                state <= ST_ERR;
                            else if (len_next == 32'd0)
                                state <= ST_CSUM;
                            else
                                state <= ST_DATA;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        // Bytes go out in arrival order; big-endian word layout comes from the image itself.
                        wr_en   <= 1'b1;
                        wr_addr <= BASE_ADDR + cnt_ext;
                        wr_data <= in_data;
                        sum     <= sum + in_data;
                        cnt     <= cnt + CNT_W'(1);
                        if (cnt_ext == len - 32'd1)
                            state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (accept)
                        state <= (in_data == sum) ? ST_DONE : ST_ERR;
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state <= ST_LEN;
                        cnt   <= '0;
                        len   <= '0;
                        sum   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// tb_instr_loader: randomized image loads checked against a queue-based model
// of the expected memory writes, final status and reset behaviour.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int          MEM  = DEFAULT_MEM_BYTES;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    instr_loader #(.MEM_BYTES(MEM), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic [7:0]  pay_q[$];

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = in_ready;
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    function automatic int pick_gap(input int maxgap);
        if (maxgap == 0 || $urandom_range(0, 2) != 0) return 0;
        return int'($urandom_range(1, maxgap));
    endfunction

    // Full load of pay_q under header length L; the model is just the image rules.
    task automatic run_load(input string tag, input logic [31:0] L, input logic [7:0] csum,
                            input int maxgap, input bit mid_start);
        bit          fits;
        bit          exp_done;
        logic [7:0]  s = 8'h00;
        int          n_exp;
        fits = (L <= 32'(MEM));
        for (int k = 0; k < pay_q.size(); k++) s = s + pay_q[k];
        exp_done = fits && (csum == s);
        n_exp    = fits ? int'(L) : 0;
        got_addr.delete();
        got_data.delete();

        pulse_start();
        for (int i = 0; i < HDR_BYTES; i++) send(L[31-8*i -: 8], pick_gap(maxgap));
        if (!fits) begin
            #1;
            check({tag, "_err_after_hdr"}, 32'(err), 32'd1);
            check({tag, "_ready_after_hdr"}, 32'(in_ready), 32'd0);
        end else begin
            for (int k = 0; k < n_exp; k++) begin
                if (mid_start && k == 2) start = 1'b1;
                send(pay_q[k], pick_gap(maxgap));
                start = 1'b0;
            end
            send(csum, pick_gap(maxgap));
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(n_exp));
        for (int k = 0; k < n_exp && k < got_addr.size(); k++) begin
            check({tag, "_addr"}, got_addr[k], BASE + 32'(k));
            check({tag, "_data"}, 32'(got_data[k]), 32'(pay_q[k]));
            if (got_addr[k] !== BASE + 32'(k) || got_data[k] !== pay_q[k]) break;
        end
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(!exp_done));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [7:0] sum_of_payload();
        logic [7:0] s = 8'h00;
        foreach (pay_q[k]) s = s + pay_q[k];
        return s;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Stray bytes in IDLE without start.
        got_addr.delete();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_nwrites", 32'(got_addr.size()), 32'd0);

        pay_q = '{8'h13, 8'h05, 8'h90, 8'h00};
        run_load("good4", 32'd4, 8'hA8, 0, 1'b0);
        run_load("badcs4", 32'd4, 8'hA9, 0, 1'b0);
        pay_q.delete();
        run_load("over1025", 32'd1025, 8'h00, 0, 1'b0);
        run_load("overbig", 32'hFFFF_0000, 8'h00, 1, 1'b0);
        run_load("len0_ok", 32'd0, 8'h00, 0, 1'b0);
        run_load("len0_bad", 32'd0, 8'h01, 0, 1'b0);

        fill_random(9);
        run_load("midstart", 32'd9, sum_of_payload(), 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int n = int'($urandom_range(1, 40));
            fill_random(n);
            if ($urandom_range(0, 1) == 0)
                run_load("rand_good", 32'(n), sum_of_payload(), 3, 1'b0);
            else
                run_load("rand_bad", 32'(n), sum_of_payload() + 8'($urandom_range(1, 255)), 3, 1'b0);
        end

        fill_random(MEM);
        run_load("full", 32'(MEM), sum_of_payload(), 3, 1'b0);

        // Stray bytes after DONE must not write or disturb status.
        got_addr.delete();
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("done_stray_nwrites", 32'(got_addr.size()), 32'd0);
        check("done_stray_done", 32'(done), 32'd1);

        // Reset in the middle of the payload.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < HDR_BYTES; i++) send((i == 3) ? 8'h10 : 8'h00, 0);
        send(8'hC1, 0);
        send(8'hC2, 0);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1 check_reset_values("midrst");
        repeat (3) @(negedge clk);
        check("midrst_nwrites", 32'(got_addr.size()), 32'd2);
        rst_n = 1'b1;

        fill_random(MEM);
        run_load("after_rst", 32'(MEM), sum_of_payload(), 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter MEM_BYTES, default 1024, meaning instruction memory size in bytes.
REQ-002 Parameter BASE_ADDR, default 32'h0, meaning byte address of the first payload byte.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a new load.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  byte write strobe to instruction memory.
REQ-010 wr_addr  output  32  byte address for the write.
REQ-011 wr_data  output  8  byte written.
REQ-012 cpu_hold  output  1  holds the core in reset while the image is incomplete.
REQ-013 done  output  1  image loaded, checksum good.
REQ-014 err  output  1  load aborted: oversize length or checksum mismatch.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 only in LEN, DATA and CSUM, as a function of the registered state only.
REQ-018 start in IDLE, DONE or ERR SHALL move to LEN and clear the byte counter, the length, the running sum, done and err; start in LEN, DATA or CSUM SHALL be ignored.
REQ-019 LEN SHALL accept exactly 4 bytes forming a 32-bit length, most significant byte first.
REQ-020 After the 4th length byte: length > MEM_BYTES -> ERR; length == 0 -> CSUM; otherwise -> DATA.
REQ-021 In DATA the k-th accepted byte (k from 0) SHALL be written to BASE_ADDR+k; the loader moves to CSUM after byte length-1.
REQ-022 Each DATA acceptance SHALL produce exactly one wr_en pulse in the following cycle, with wr_addr and wr_data registered (write latency 1 cycle).
REQ-023 Because the memory is read big-endian, the first payload byte of each word SHALL be its most significant byte; the loader performs no reordering.
REQ-024 The running sum SHALL be an 8-bit sum, modulo 256, of all payload bytes.
REQ-025 In CSUM one byte SHALL be accepted: equal to the running sum -> DONE, otherwise -> ERR.
REQ-026 done SHALL be 1 exactly while in DONE; err SHALL be 1 exactly while in ERR.
REQ-027 cpu_hold SHALL be 0 only in DONE, and 1 in every other state including IDLE.
REQ-028 wr_en SHALL be 0 outside the cycle following a DATA acceptance; wr_addr and wr_data hold their last values while wr_en is 0.
REQ-029 Back-to-back acceptances, one byte every cycle, SHALL be sustained with no dropped bytes.
REQ-030 in_valid without start in IDLE, DONE or ERR SHALL be ignored, with no write.

Reset
REQ-031 While rst_n is 0: state IDLE; in_ready, wr_en, done and err 0; cpu_hold 1; wr_addr 0; wr_data 0; counters and sum 0.
REQ-032 Reset mid-load SHALL abort immediately, with no further writes; memory contents already written are not restored.

Structure
REQ-033 State encodings, the 4-byte header size, and the default MEM_BYTES SHALL live in a shared package used by the memory and the loader.
REQ-034 The block SHALL be one module with no sub-module.
REQ-035 The byte counter SHALL be wide enough to count MEM_BYTES without wrap-around.

Verification
REQ-036 start; stream 00 00 00 04, 13 05 90 00, csum A8 -> writes 0..3 = 13,05,90,00; done=1; cpu_hold=0.
REQ-037 Same stream with csum A9 -> 4 writes occur, then err=1, done=0, cpu_hold=1.
REQ-038 Length 00 00 04 01 (1025) -> ERR right after the 4th length byte, no wr_en pulse ever.
REQ-039 Length 0 followed by csum 00 -> DONE with zero writes; csum 01 -> ERR.
REQ-040 Random in_valid gaps plus a 1024-byte image -> 1024 writes, addresses 0..1023 in order, done=1.
REQ-041 rst_n low after 2 payload bytes -> outputs at reset values at once; a new start plus a full image loads correctly.
